// File: rtl/sprite_sequencer_pkg.sv
// sprite_pkg: shared types and constants for the sprite blocks.
//   seq_state_t  : sequencer state (IDLE, PLAY, HOLD, DONE)
//   ST_*         : game FSM scene codes carried on `status`
//   SCREEN_W/H   : visible screen size in pixels
package sprite_pkg;

  typedef enum logic [1:0] {IDLE, PLAY, HOLD, DONE} seq_state_t;

  localparam logic [3:0] ST_INTRO  = 4'd3;
  localparam logic [3:0] ST_FLOWER = 4'd5;
  localparam logic [3:0] ST_BATTLE = 4'd6;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

endpackage

// File: rtl/sprite_sequencer_if.sv
// sprite_sequencer_if: game-FSM control and pixel bus of the sprite sequencer.
//   master (game/video side): drives status, pause, DrawX, DrawY
//   slave  (sequencer)      : drives is_sprite, frame_sel, sprite_address,
//                             start_bullet, time_up
interface sprite_sequencer_if #(parameter int ADDR_W = 20);
  logic [3:0]        status;
  logic              pause;
  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic              is_sprite;
  logic [2:0]        frame_sel;
  logic [ADDR_W-1:0] sprite_address;
  logic              start_bullet;
  logic              time_up;

  modport master (
    output status, pause, DrawX, DrawY,
    input  is_sprite, frame_sel, sprite_address, start_bullet, time_up
  );

  modport slave (
    input  status, pause, DrawX, DrawY,
    output is_sprite, frame_sel, sprite_address, start_bullet, time_up
  );
endinterface

// File: rtl/sprite_window.sv
// sprite_window: combinational window test and ROM address for one sprite.
//   DrawX_i, DrawY_i : pixel coordinates
//   inside_o         : SPR_X <= x < SPR_X+SPR_W and SPR_Y <= y < SPR_Y+SPR_H
//   addr_o           : (x-SPR_X) + (y-SPR_Y)*SPR_W, 0 outside the window
module sprite_window import sprite_pkg::*; #(
  parameter int SPR_X  = 279,
  parameter int SPR_Y  = 124,
  parameter int SPR_W  = 82,
  parameter int SPR_H  = 86,
  parameter int ADDR_W = 20
) (
  input  logic [9:0]        DrawX_i,
  input  logic [9:0]        DrawY_i,
  output logic              inside_o,
  output logic [ADDR_W-1:0] addr_o
);
  // Bounds sized to the coordinate bus so the compares are same-width.
  localparam logic [9:0] X_LO = 10'(SPR_X);
  localparam logic [9:0] X_HI = 10'(SPR_X + SPR_W);
  localparam logic [9:0] Y_LO = 10'(SPR_Y);
  localparam logic [9:0] Y_HI = 10'(SPR_Y + SPR_H);
  localparam logic [ADDR_W-1:0] W_A = ADDR_W'(SPR_W);

  logic [ADDR_W-1:0] dx, dy;

  assign inside_o = (DrawX_i >= X_LO) && (DrawX_i < X_HI) &&
                    (DrawY_i >= Y_LO) && (DrawY_i < Y_HI);
  assign dx       = ADDR_W'(DrawX_i - X_LO);
  assign dy       = ADDR_W'(DrawY_i - Y_LO);
  assign addr_o   = inside_o ? (dx + dy * W_A) : '0;
endmodule

// File: rtl/sprite_sequencer.sv
// sprite_sequencer: frame-clocked sprite animation sequencer.
//   frame_clk : frame clock (vsync), only clock
//   Reset_n   : synchronous active-low reset
//   bus       : sprite_sequencer_if.slave (status/pause/pixel in,
//               is_sprite/frame_sel/sprite_address/start_bullet/time_up out)
// Build option: SPRITE_SEQ_LOOP_EN keeps frames cycling while in HOLD.
module sprite_sequencer import sprite_pkg::*; #(
  parameter int         NUM_FRAMES = 3,
  parameter int         FRAME_HOLD = 120,
  parameter int         TIMEOUT    = 3840,
  parameter int         SPR_X      = 279,
  parameter int         SPR_Y      = 124,
  parameter int         SPR_W      = 82,
  parameter int         SPR_H      = 86,
  parameter logic [3:0] ACT_STATUS = ST_FLOWER,
  parameter int         ADDR_W     = 20
) (
  input logic              frame_clk,
  input logic              Reset_n,
  sprite_sequencer_if.slave bus
);
  localparam int SW = $clog2(TIMEOUT);
  localparam int HW = $clog2(FRAME_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(FRAME_HOLD - 1);
  localparam logic [SW-1:0] SCENE_LAST = SW'(TIMEOUT - 1);
  localparam logic [2:0]    FRM_LAST   = 3'(NUM_FRAMES - 1);
  localparam logic [2:0]    FRM_PRE    = 3'(NUM_FRAMES - 2);
`ifdef SPRITE_SEQ_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  seq_state_t    state_q, state_d;
  logic [2:0]    frame_q, frame_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [SW-1:0] scene_q, scene_d;
  logic          bullet_q, bullet_d;
  logic          timeup_q, timeup_d;
  logic          step;

  always_ff @(posedge frame_clk) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      frame_q  <= '0;
      hold_q   <= '0;
      scene_q  <= '0;
      bullet_q <= 1'b0;
      timeup_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      hold_q   <= hold_d;
      scene_q  <= scene_d;
      bullet_q <= bullet_d;
      timeup_q <= timeup_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    hold_d   = hold_q;
    scene_d  = scene_q;
    bullet_d = bullet_q;
    timeup_d = timeup_q;
    step     = (hold_q == HOLD_LAST);

    // Leaving the scene wins over pause: everything drops back to idle.
    if (bus.status != ACT_STATUS) begin
      state_d  = IDLE;
      frame_d  = '0;
      hold_d   = '0;
      scene_d  = '0;
      bullet_d = 1'b0;
      timeup_d = 1'b0;
    end else if (!bus.pause) begin
      unique case (state_q)
        IDLE: begin
          state_d = PLAY;
          frame_d = '0;
          hold_d  = '0;
          scene_d = '0;
        end
        PLAY, HOLD: begin
          scene_d = scene_q + 1'b1;
          // Frames advance in PLAY always; in HOLD only when looping.
          if (state_q == PLAY || LOOP_EN) begin
            hold_d = step ? '0 : hold_q + 1'b1;
            if (step) frame_d = (frame_q == FRM_LAST) ? '0 : frame_q + 1'b1;
          end
          if (state_q == PLAY && step && frame_q == FRM_PRE) begin
            state_d  = HOLD;
            bullet_d = 1'b1;
          end
          // Timeout overrides the HOLD transition but keeps bullet set.
          if (scene_q == SCENE_LAST) begin
            state_d  = DONE;
            scene_d  = scene_q;
            timeup_d = 1'b1;
          end
        end
        default: ; // DONE: frozen until status changes
      endcase
    end
  end

  logic              win_in;
  logic [ADDR_W-1:0] win_addr;

  sprite_window #(
    .SPR_X(SPR_X), .SPR_Y(SPR_Y), .SPR_W(SPR_W), .SPR_H(SPR_H), .ADDR_W(ADDR_W)
  ) u_win (
    .DrawX_i (bus.DrawX),
    .DrawY_i (bus.DrawY),
    .inside_o(win_in),
    .addr_o  (win_addr)
  );

  assign bus.is_sprite      = win_in && (state_q != IDLE);
  assign bus.sprite_address = bus.is_sprite ? win_addr : '0;
  assign bus.frame_sel      = frame_q;
  assign bus.start_bullet   = bullet_q;
  assign bus.time_up        = timeup_q;
endmodule

// File: tb/tb_sprite_sequencer.sv
module tb_sprite_sequencer;
  localparam int NF = 3, FH = 120, TO = 3840;
  localparam int SX = 279, SY = 124, SWD = 82, SHT = 86;

  logic frame_clk = 1'b0;
  logic Reset_n   = 1'b0;
  int total = 0, bad = 0;
  int t = -1;  // model: active unpaused edges since PLAY entry, -1 = idle

  sprite_sequencer_if #(.ADDR_W(20)) bus ();
  sprite_sequencer dut (.frame_clk(frame_clk), .Reset_n(Reset_n), .bus(bus));

  always #5 frame_clk = ~frame_clk;

  // ---------------- reference model ----------------
  function automatic logic [2:0] exp_frame(int tt);
    int c;
    if (tt < 0) return 3'd0;
    c = (tt > TO) ? TO : tt;
`ifdef SPRITE_SEQ_LOOP_EN
    return 3'((c / FH) % NF);
`else
    return 3'(((c / FH) > NF - 1) ? NF - 1 : c / FH);
`endif
  endfunction
  function automatic logic exp_bullet(int tt); return tt >= (NF - 1) * FH; endfunction
  function automatic logic exp_tup(int tt);    return tt >= TO; endfunction
  function automatic logic exp_in(int tt, int x, int y);
    return tt >= 0 && x >= SX && x < SX + SWD && y >= SY && y < SY + SHT;
  endfunction
  function automatic logic [19:0] exp_addr(int tt, int x, int y);
    return exp_in(tt, x, y) ? 20'((x - SX) + (y - SY) * SWD) : 20'd0;
  endfunction

  task automatic tick();
    @(posedge frame_clk);
    if (!Reset_n || bus.status != 4'd5) t = -1;
    else if (!bus.pause) begin
      if (t < 0) t = 0;
      else if (t < TO) t++;
    end
    #1;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // restart a scene: leave status, then re-enter (one entry edge)
  task automatic enter_scene();
    bus.status = 4'd0; bus.pause = 1'b0; tick();
    bus.status = 4'd5; tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    Reset_n = 1'b0; bus.status = 4'd5; bus.pause = 1'b0;
    bus.DrawX = 10'd300; bus.DrawY = 10'd150;
    ticks(2);
    #1;
    total++; if (bus.frame_sel !== 3'd0) begin bad++; $display("FAIL rst_frame got %0d want 0", bus.frame_sel); end
    total++; if (bus.time_up !== 1'b0) begin bad++; $display("FAIL rst_timeup got %b want 0", bus.time_up); end
    total++; if (bus.start_bullet !== 1'b0) begin bad++; $display("FAIL rst_bullet got %b want 0", bus.start_bullet); end
    total++; if (bus.is_sprite !== 1'b0) begin bad++; $display("FAIL rst_is_sprite got %b want 0", bus.is_sprite); end
    total++; if (bus.sprite_address !== 20'd0) begin bad++; $display("FAIL rst_addr got %0d want 0", bus.sprite_address); end
    Reset_n = 1'b1;
  endtask

  task automatic test_frame_stepping();
    enter_scene();
    ticks(119);
    total++; if (bus.frame_sel !== 3'd0) begin bad++; $display("FAIL step119 frame got %0d want 0", bus.frame_sel); end
    tick();
    total++; if (bus.frame_sel !== 3'd1) begin bad++; $display("FAIL step120 frame got %0d want 1", bus.frame_sel); end
    ticks(119);
    total++; if (bus.start_bullet !== 1'b0) begin bad++; $display("FAIL step239 bullet got %b want 0", bus.start_bullet); end
    tick();
    total++; if (bus.frame_sel !== 3'd2) begin bad++; $display("FAIL step240 frame got %0d want 2", bus.frame_sel); end
    total++; if (bus.start_bullet !== 1'b1) begin bad++; $display("FAIL step240 bullet got %b want 1", bus.start_bullet); end
    ticks(TO - 1 - 240);
    total++; if (bus.time_up !== 1'b0) begin bad++; $display("FAIL step3839 time_up got %b want 0", bus.time_up); end
    tick();
    total++; if (bus.time_up !== 1'b1) begin bad++; $display("FAIL step3840 time_up got %b want 1", bus.time_up); end
    total++; if (bus.frame_sel !== exp_frame(t)) begin bad++; $display("FAIL done_frame got %0d want %0d", bus.frame_sel, exp_frame(t)); end
    ticks(5);
    total++; if (bus.time_up !== 1'b1 || bus.start_bullet !== 1'b1) begin bad++; $display("FAIL done_hold tu=%b sb=%b want 1 1", bus.time_up, bus.start_bullet); end
  endtask

  task automatic test_window();
    int px[4] = '{279, 360, 361, 279};
    int py[4] = '{124, 209, 124, 210};
    logic       ein[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [19:0] ead[4] = '{20'd0, 20'd7051, 20'd0, 20'd0};
    enter_scene();
    ticks(10);
    for (int i = 0; i < 4; i++) begin
      bus.DrawX = 10'(px[i]); bus.DrawY = 10'(py[i]); #1;
      total++; if (bus.is_sprite !== ein[i] || bus.sprite_address !== ead[i]) begin
        bad++; $display("FAIL win_edge(%0d,%0d) got in=%b addr=%0d want in=%b addr=%0d",
                        px[i], py[i], bus.is_sprite, bus.sprite_address, ein[i], ead[i]);
      end
    end
    for (int i = 0; i < 40; i++) begin
      int x = $urandom_range(270, 370), y = $urandom_range(115, 220);
      bus.DrawX = 10'(x); bus.DrawY = 10'(y); #1;
      total++; if (bus.is_sprite !== exp_in(t, x, y) || bus.sprite_address !== exp_addr(t, x, y)) begin
        bad++; $display("FAIL win_rand(%0d,%0d) got in=%b addr=%0d want in=%b addr=%0d",
                        x, y, bus.is_sprite, bus.sprite_address, exp_in(t, x, y), exp_addr(t, x, y));
      end
    end
  endtask

  task automatic test_pause();
    enter_scene();
    ticks(99);
    bus.pause = 1'b1; ticks(50); bus.pause = 1'b0;
    total++; if (bus.frame_sel !== 3'd0) begin bad++; $display("FAIL pause_frozen frame got %0d want 0", bus.frame_sel); end
    ticks(169 - 149);
    total++; if (bus.frame_sel !== 3'd0) begin bad++; $display("FAIL pause169 frame got %0d want 0", bus.frame_sel); end
    tick();
    total++; if (bus.frame_sel !== 3'd1) begin bad++; $display("FAIL pause170 frame got %0d want 1", bus.frame_sel); end
    ticks(3889 - 170);
    total++; if (bus.time_up !== 1'b0) begin bad++; $display("FAIL pause3889 time_up got %b want 0", bus.time_up); end
    tick();
    total++; if (bus.time_up !== 1'b1) begin bad++; $display("FAIL pause3890 time_up got %b want 1", bus.time_up); end
  endtask

  task automatic test_abort();
    bus.DrawX = 10'd300; bus.DrawY = 10'd150;
    enter_scene();
    ticks(199);
    bus.status = 4'd3; bus.pause = 1'b1;  // status change must beat pause
    tick();
    bus.pause = 1'b0;
    total++; if (bus.frame_sel !== 3'd0 || bus.start_bullet !== 1'b0 || bus.time_up !== 1'b0 ||
                 bus.is_sprite !== 1'b0 || bus.sprite_address !== 20'd0) begin
      bad++; $display("FAIL abort got fs=%0d sb=%b tu=%b in=%b addr=%0d want all 0",
                      bus.frame_sel, bus.start_bullet, bus.time_up, bus.is_sprite, bus.sprite_address);
    end
    bus.status = 4'd5; tick();
    total++; if (bus.frame_sel !== 3'd0 || bus.is_sprite !== 1'b1) begin
      bad++; $display("FAIL abort_restart got fs=%0d in=%b want 0 1", bus.frame_sel, bus.is_sprite);
    end
    ticks(120);
    total++; if (bus.frame_sel !== 3'd1) begin bad++; $display("FAIL abort_step got %0d want 1", bus.frame_sel); end
  endtask

  task automatic test_loop();
    logic [2:0] want;
`ifdef SPRITE_SEQ_LOOP_EN
    want = 3'd0;
`else
    want = 3'd2;
`endif
    enter_scene();
    ticks(359);
    total++; if (bus.frame_sel !== 3'd2) begin bad++; $display("FAIL loop359 frame got %0d want 2", bus.frame_sel); end
    tick();
    total++; if (bus.frame_sel !== want) begin bad++; $display("FAIL loop360 frame got %0d want %0d", bus.frame_sel, want); end
    total++; if (bus.start_bullet !== 1'b1) begin bad++; $display("FAIL loop360 bullet got %b want 1", bus.start_bullet); end
  endtask

  task automatic test_random();
    enter_scene();
    for (int i = 0; i < 9000; i++) begin
      int r = $urandom_range(0, 999);
      int x = $urandom_range(260, 380), y = $urandom_range(100, 230);
      Reset_n    = (r != 0);
      bus.status = (r >= 1 && r <= 2) ? 4'(r + 1) : 4'd5;
      bus.pause  = ($urandom_range(0, 9) == 0);
      bus.DrawX  = 10'(x); bus.DrawY = 10'(y);
      tick();
      total++; if (bus.frame_sel !== exp_frame(t) || bus.start_bullet !== exp_bullet(t) ||
                   bus.time_up !== exp_tup(t) || bus.is_sprite !== exp_in(t, x, y) ||
                   bus.sprite_address !== exp_addr(t, x, y)) begin
        bad++; $display("FAIL rand[%0d] got fs=%0d sb=%b tu=%b in=%b addr=%0d want fs=%0d sb=%b tu=%b in=%b addr=%0d",
                        i, bus.frame_sel, bus.start_bullet, bus.time_up, bus.is_sprite, bus.sprite_address,
                        exp_frame(t), exp_bullet(t), exp_tup(t), exp_in(t, x, y), exp_addr(t, x, y));
      end
    end
    Reset_n = 1'b1; bus.pause = 1'b0;
  endtask

  initial begin
    test_reset();
    test_frame_stepping();
    test_window();
    test_pause();
    test_abort();
    test_loop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
